button_pulse_gen: RTL and testbench



---
 rtl/btn_pkg.sv | 21 ++
 rtl/button_pulse_gen_if.sv | 26 ++
 rtl/sync_2ff.sv | 19 +
 rtl/button_pulse_gen.sv | 141 ++++++++++++++
 tb/tb_button_pulse_gen.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the button pulse generator.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Bits needed to hold the values 0..max_val without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((64'(1) << w) <= 64'(max_val))) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/button_pulse_gen_if.sv
// Button pin and its strobe/level outputs, bundled for the pulse generator.
interface button_pulse_gen_if;
    logic btn_raw;
    logic bp;
    logic rel;
    logic long_press;
    logic held;

    // Board/consumer side: drives the pin, observes the strobes.
    modport master (
        output btn_raw,
        input  bp,
        input  rel,
        input  long_press,
        input  held
    );

    // Pulse generator side.
    modport slave (
        input  btn_raw,
        output bp,
        output rel,
        output long_press,
        output held
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; q is the second flop.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/button_pulse_gen.sv
// Debounced push-button front end: press/release strobes, held level,
// long-press strobe and optional auto-repeat presses.
module button_pulse_gen
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_CYCLES   = 20000000
) (
    input logic               clk,
    input logic               reset,
    button_pulse_gen_if.slave btn
);
    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HW = cnt_width(LONG_CYCLES);
    localparam int unsigned RW = cnt_width(REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic btn_sync;

    btn_state_t    state, state_n;
    logic [DW-1:0] deb_cnt, deb_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [RW-1:0] rep_cnt, rep_n;
    logic          bp_q, bp_n;
    logic          rel_q, rel_n;
    logic          long_q, long_n;
    logic          held_q, held_n;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn.btn_raw),
        .q     (btn_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            bp_q     <= 1'b0;
            rel_q    <= 1'b0;
            long_q   <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state    <= state_n;
            deb_cnt  <= deb_n;
            hold_cnt <= hold_n;
            rep_cnt  <= rep_n;
            bp_q     <= bp_n;
            rel_q    <= rel_n;
            long_q   <= long_n;
            held_q   <= held_n;
        end
    end

    always_comb begin
        state_n = state;
        deb_n   = deb_cnt;
        hold_n  = hold_cnt;
        rep_n   = rep_cnt;
        bp_n    = 1'b0;
        rel_n   = 1'b0;
        long_n  = 1'b0;

        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_n = PRESS_WAIT;
                    deb_n   = DW'(1);
                end
            end

            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_n = IDLE;
                    deb_n   = '0;
                end else if (deb_cnt >= DEB_MAX) begin
                    state_n = PRESSED;
                    deb_n   = '0;
                    hold_n  = '0;
                    rep_n   = '0;
                    bp_n    = 1'b1;
                end else begin
                    deb_n = deb_cnt + DW'(1);
                end
            end

            // Hold counter saturates at LONG_CYCLES; repeats only run once it has.
            PRESSED: begin
                if (!btn_sync) begin
                    state_n = RELEASE_WAIT;
                    deb_n   = DW'(1);
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_n = hold_cnt + HW'(1);
                    long_n = (hold_cnt == HOLD_LAST);
                end else if (REPEAT_EN != 0) begin
                    if (rep_cnt == REP_LAST) begin
                        rep_n = '0;
                        bp_n  = 1'b1;
                    end else begin
                        rep_n = rep_cnt + RW'(1);
                    end
                end
            end

            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_n = PRESSED;
                    deb_n   = '0;
                end else if (deb_cnt >= DEB_MAX) begin
                    state_n = IDLE;
                    deb_n   = '0;
                    rel_n   = 1'b1;
                end else begin
                    deb_n = deb_cnt + DW'(1);
                end
            end

            default: begin
                state_n = IDLE;
                deb_n   = '0;
            end
        endcase

        // Level stays up through the release strobe cycle itself.
        held_n = (state_n == PRESSED) || (state_n == RELEASE_WAIT) || rel_n;
    end

    assign btn.bp         = bp_q;
    assign btn.rel        = rel_q;
    assign btn.long_press = long_q;
    assign btn.held       = held_q;
endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: two instances (repeat off / on) share one button.
`timescale 1ns/1ps
module tb_button_pulse_gen;
    localparam int unsigned D = 4;
    localparam int unsigned L = 20;
    localparam int unsigned R = 8;

    typedef struct {
        int hold;      // cycles the raw button is held
        bit press;     // a debounced press is expected
        bit lng;       // long_press is expected
        int reps;      // auto-repeat bp pulses expected with repeat enabled
    } vec_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    int   q_bp_a[$], q_rel_a[$], q_long_a[$], q_held_a[$];
    int   q_bp_b[$], q_rel_b[$], q_long_b[$], q_held_b[$];
    logic lvl_a, lvl_b;

    button_pulse_gen_if ifa ();
    button_pulse_gen_if ifb ();

    button_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_EN       (0),
        .REPEAT_CYCLES   (R)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .btn   (ifa)
    );

    button_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_EN       (1),
        .REPEAT_CYCLES   (R)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .btn   (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse scoreboard: a pulse must appear exactly at the queued cycle and nowhere else.
    task automatic chk_pulse(input string name, input logic act, ref int q[$]);
        logic exp_v;
        exp_v = (q.size() > 0) && (q[0] == cyc);
        if (exp_v) void'(q.pop_front());
        if (act !== 1'b0 || exp_v) begin
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp_v);
            end
        end
    endtask

    task automatic chk_level(input string name, input logic act, ref int q[$], ref logic lvl);
        if (q.size() > 0 && q[0] == cyc) begin
            void'(q.pop_front());
            lvl = ~lvl;
        end
        checks++;
        if (act !== lvl) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, lvl);
        end
    endtask

    always @(negedge clk) begin
        chk_pulse("bp_a",   ifa.bp,         q_bp_a);
        chk_pulse("rel_a",  ifa.rel,        q_rel_a);
        chk_pulse("long_a", ifa.long_press, q_long_a);
        chk_level("held_a", ifa.held,       q_held_a, lvl_a);
        chk_pulse("bp_b",   ifb.bp,         q_bp_b);
        chk_pulse("rel_b",  ifb.rel,        q_rel_b);
        chk_pulse("long_b", ifb.long_press, q_long_b);
        chk_level("held_b", ifb.held,       q_held_b, lvl_b);
    end

    task automatic chk_eq(input string name, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_bp_a"},   ifa.bp,         1'b0);
        chk_eq({tag, "_rel_a"},  ifa.rel,        1'b0);
        chk_eq({tag, "_long_a"}, ifa.long_press, 1'b0);
        chk_eq({tag, "_held_a"}, ifa.held,       1'b0);
        chk_eq({tag, "_bp_b"},   ifb.bp,         1'b0);
        chk_eq({tag, "_held_b"}, ifb.held,       1'b0);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic v);
        ifa.btn_raw = v;
        ifb.btn_raw = v;
    endtask

    task automatic push_press(input int t);
        q_bp_a.push_back(t);
        q_bp_b.push_back(t);
        q_held_a.push_back(t);
        q_held_b.push_back(t);
    endtask

    // m = first edge sampling 0; rel lands D+2 edges later, held drops the cycle after.
    task automatic push_release(input int m);
        q_rel_a.push_back(m + D + 2);
        q_rel_b.push_back(m + D + 2);
        q_held_a.push_back(m + D + 3);
        q_held_b.push_back(m + D + 3);
    endtask

    // Inputs change #1 after edge cyc, so the first edge to sample them is cyc+1.
    task automatic run_vec(input vec_t v, input int gap);
        int k, t;
        k = cyc + 1;
        t = k + D + 2;
        if (v.press) begin
            push_press(t);
            if (v.lng) begin
                q_long_a.push_back(t + L);
                q_long_b.push_back(t + L);
            end
            for (int n = 1; n <= v.reps; n++) q_bp_b.push_back(t + L + n * R);
            push_release(k + v.hold);
        end
        set_btn(1'b1);
        repeat (v.hold) next_edge();
        set_btn(1'b0);
        repeat (gap) next_edge();
    endtask

    task automatic chk_empty(input string name, input int sz);
        checks++;
        if (sz != 0) begin
            failures++;
            $display("FAIL %s leftover_expected_events actual=%0d required=0", name, sz);
        end
    endtask

    vec_t vecs[9];

    initial begin
        int k, t, m;
        checks   = 0;
        failures = 0;
        lvl_a    = 1'b0;
        lvl_b    = 1'b0;
        reset    = 1'b1;
        set_btn(1'b0);

        vecs[0] = '{hold: 10, press: 1'b1, lng: 1'b0, reps: 0};
        vecs[1] = '{hold:  4, press: 1'b0, lng: 1'b0, reps: 0};
        vecs[2] = '{hold:  5, press: 1'b1, lng: 1'b0, reps: 0};
        vecs[3] = '{hold: 23, press: 1'b1, lng: 1'b0, reps: 0};
        vecs[4] = '{hold: 25, press: 1'b1, lng: 1'b1, reps: 0};
        vecs[5] = '{hold: 31, press: 1'b1, lng: 1'b1, reps: 0};
        vecs[6] = '{hold: 33, press: 1'b1, lng: 1'b1, reps: 1};
        vecs[7] = '{hold: 40, press: 1'b1, lng: 1'b1, reps: 1};
        vecs[8] = '{hold: 45, press: 1'b1, lng: 1'b1, reps: 2};

        repeat (3) next_edge();
        chk_all_zero("reset");
        reset = 1'b0;

        // First press is sampled at edge 10 so its bp lands after edge 16.
        while (cyc < 9) next_edge();
        for (int i = 0; i < 9; i++) run_vec(vecs[i], 14);

        // Bounce 1,0,1,0 then quiet: nothing may come out.
        for (int i = 0; i < 4; i++) begin
            set_btn((i % 2) == 0);
            next_edge();
        end
        set_btn(1'b0);
        repeat (10) next_edge();
        chk_all_zero("bounce");

        // Reset while pressed: no rel, then the still-held button re-presses.
        k = cyc + 1;
        t = k + D + 2;
        push_press(t);
        set_btn(1'b1);
        repeat (10) next_edge();
        reset = 1'b1;
        q_held_a.push_back(cyc + 1);
        q_held_b.push_back(cyc + 1);
        next_edge();
        chk_all_zero("in_reset");
        repeat (2) next_edge();
        reset = 1'b0;
        k = cyc + 1;
        push_press(k + D + 2);
        repeat (12) next_edge();
        set_btn(1'b0);
        push_release(cyc + 1);
        repeat (14) next_edge();

        // Single-sample release glitch while pressed: no rel, no second bp.
        k = cyc + 1;
        push_press(k + D + 2);
        set_btn(1'b1);
        repeat (8) next_edge();
        set_btn(1'b0);
        next_edge();
        set_btn(1'b1);
        repeat (3) next_edge();
        chk_eq("glitch_held_a", ifa.held, 1'b1);
        repeat (2) next_edge();
        m = cyc + 1;
        set_btn(1'b0);
        push_release(m);
        repeat (20) next_edge();
        chk_all_zero("final");

        chk_empty("bp_a",   q_bp_a.size());
        chk_empty("rel_a",  q_rel_a.size());
        chk_empty("long_a", q_long_a.size());
        chk_empty("held_a", q_held_a.size());
        chk_empty("bp_b",   q_bp_b.size());
        chk_empty("rel_b",  q_rel_b.size());
        chk_empty("long_b", q_long_b.size());
        chk_empty("held_b", q_held_b.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
